// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: trace FIFO, halt latch, retire counter and store watch for VeriRISC.
// Optional macro TRACE_FILTER_EN adds an op_mask port that selects which opcodes are traced.
module cpu_trace_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3,
  parameter int DEPTH      = 16,
  parameter int WRAP       = 1,
  parameter int WATCH_CH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           fetch_valid,
  input  logic [ADDR_WIDTH-1:0]          pc_addr,
  input  logic [OP_WIDTH-1:0]            opcode,
  input  logic [ADDR_WIDTH-1:0]          ir_addr,
  input  logic [DATA_WIDTH-1:0]          data,
  input  logic                           halt,
  input  logic                           mem_wr,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [WATCH_CH*ADDR_WIDTH-1:0] watch_addr,
`ifdef TRACE_FILTER_EN
  input  logic [2**OP_WIDTH-1:0]         op_mask,
`endif
  input  logic                           rd_en,
  output logic                           rd_valid,
  output logic [ADDR_WIDTH-1:0]          rd_pc,
  output logic [OP_WIDTH-1:0]            rd_op,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full,
  output logic                           overflow,
  output logic                           halted,
  output logic [ADDR_WIDTH-1:0]          halt_pc,
  output logic [CNT_WIDTH-1:0]           instr_count,
  output logic [WATCH_CH-1:0]            watch_hit,
  output logic [WATCH_CH*DATA_WIDTH-1:0] watch_data
);

  localparam int  PW      = $clog2(DEPTH);
  localparam int  CW      = PW + 1;
  localparam int  EW      = 2 * ADDR_WIDTH + OP_WIDTH + DATA_WIDTH;
  localparam bit  WRAP_EN = (WRAP != 0);

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic           rd_valid_q, rd_valid_d;
  logic [EW-1:0]  rd_ent_q, rd_ent_d;
  logic           halted_q, halted_d;
  logic           halt_prev_q, halt_prev_d;
  logic [ADDR_WIDTH-1:0] halt_pc_q, halt_pc_d;
  logic [CNT_WIDTH-1:0]  icnt_q, icnt_d;
  logic [WATCH_CH-1:0]   hit_q, hit_d;
  logic [WATCH_CH*DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic full_w, empty_w, acc, cap, pop, mem_we, rise;
  logic [EW-1:0] wr_ent;

  assign full_w  = (cnt_q == CW'(DEPTH));
  assign empty_w = (cnt_q == '0);
  assign acc     = fetch_valid && !halted_q;
`ifdef TRACE_FILTER_EN
  assign cap     = acc && op_mask[opcode];
`else
  assign cap     = acc;
`endif
  assign pop     = rd_en && !empty_w;
  // When full without a pop, only the overwrite mode stores the entry.
  assign mem_we  = cap && (pop || !full_w || WRAP_EN);
  assign rise    = halt && !halt_prev_q;
  assign wr_ent  = {pc_addr, opcode, ir_addr, data};

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    rd_valid_d  = pop;
    rd_ent_d    = rd_ent_q;
    halted_d    = halted_q | rise;
    halt_prev_d = halt;
    halt_pc_d   = rise ? pc_addr : halt_pc_q;
    icnt_d      = icnt_q;
    hit_d       = '0;
    wdata_d     = wdata_q;

    if (pop) begin
      rd_ent_d = mem_q[rptr_q];
      rptr_d   = rptr_q + PW'(1);
    end
    if (mem_we) wptr_d = wptr_q + PW'(1);

    unique case (1'b1)
      cap && !pop && full_w: begin
        ovf_d = 1'b1;
        if (WRAP_EN) rptr_d = rptr_q + PW'(1);
      end
      cap && !pop && !full_w: cnt_d = cnt_q + CW'(1);
      pop && !cap:            cnt_d = cnt_q - CW'(1);
      default: ;
    endcase

    if (acc && !(&icnt_q)) icnt_d = icnt_q + CNT_WIDTH'(1);

    for (int i = 0; i < WATCH_CH; i++) begin
      hit_d[i] = mem_wr &&
        (wr_addr == watch_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      if (hit_d[i]) wdata_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst || clr) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_ent_q    <= '0;
      halted_q    <= 1'b0;
      halt_prev_q <= 1'b0;
      halt_pc_q   <= '0;
      icnt_q      <= '0;
      hit_q       <= '0;
      wdata_q     <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_ent_q    <= rd_ent_d;
      halted_q    <= halted_d;
      halt_prev_q <= halt_prev_d;
      halt_pc_q   <= halt_pc_d;
      icnt_q      <= icnt_d;
      hit_q       <= hit_d;
      wdata_q     <= wdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!(rst || clr) && mem_we) mem_q[wptr_q] <= wr_ent;
  end

  assign {rd_pc, rd_op, rd_addr, rd_data} = rd_ent_q;
  assign rd_valid    = rd_valid_q;
  assign count       = cnt_q;
  assign empty       = empty_w;
  assign full        = full_w;
  assign overflow    = ovf_q;
  assign halted      = halted_q;
  assign halt_pc     = halt_pc_q;
  assign instr_count = icnt_q;
  assign watch_hit   = hit_q;
  assign watch_data  = wdata_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: overwrite (g=1) and drop (g=0) instances
// checked against a queue model, fixed sequences and a watch table.
module tb_cpu_trace_buffer;
  localparam int AW = 5, DW = 8, OW = 3, D = 16, WC = 2, NW = 16;
  localparam int CW = $clog2(D) + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [OW-1:0] op;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
  } ent_t;

  typedef struct {
    logic [WC*AW-1:0] wa;
    logic             wr;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    logic [WC-1:0]    hit;
    logic [DW-1:0]    d0;
    logic [DW-1:0]    d1;
  } wv_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, clr, fetch_valid, halt, mem_wr, rd_en;
  logic [AW-1:0] pc_addr, ir_addr, wr_addr;
  logic [OW-1:0] opcode;
  logic [DW-1:0] data, wr_data;
  logic [WC*AW-1:0] watch_addr;
`ifdef TRACE_FILTER_EN
  logic [2**OW-1:0] op_mask = '1;
`endif

  logic          rd_valid_o [2];
  logic [AW-1:0] rd_pc_o    [2];
  logic [OW-1:0] rd_op_o    [2];
  logic [AW-1:0] rd_addr_o  [2];
  logic [DW-1:0] rd_data_o  [2];
  logic [CW-1:0] count_o    [2];
  logic          empty_o    [2];
  logic          full_o     [2];
  logic          ovf_o      [2];
  logic          halted_o   [2];
  logic [AW-1:0] hpc_o      [2];
  logic [NW-1:0] ic_o       [2];
  logic [WC-1:0] hit_o      [2];
  logic [WC*DW-1:0] wd_o    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_trace_buffer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OP_WIDTH(OW),
      .DEPTH(D), .WRAP(g), .WATCH_CH(WC), .CNT_WIDTH(NW)
    ) u_dut (
      .clock(clock), .rst(rst), .clr(clr),
      .fetch_valid(fetch_valid), .pc_addr(pc_addr),
      .opcode(opcode), .ir_addr(ir_addr), .data(data),
      .halt(halt), .mem_wr(mem_wr), .wr_addr(wr_addr),
      .wr_data(wr_data), .watch_addr(watch_addr),
`ifdef TRACE_FILTER_EN
      .op_mask(op_mask),
`endif
      .rd_en(rd_en), .rd_valid(rd_valid_o[g]),
      .rd_pc(rd_pc_o[g]), .rd_op(rd_op_o[g]),
      .rd_addr(rd_addr_o[g]), .rd_data(rd_data_o[g]),
      .count(count_o[g]), .empty(empty_o[g]),
      .full(full_o[g]), .overflow(ovf_o[g]),
      .halted(halted_o[g]), .halt_pc(hpc_o[g]),
      .instr_count(ic_o[g]), .watch_hit(hit_o[g]),
      .watch_data(wd_o[g])
    );
  end

  int checks = 0;
  int errors = 0;

  ent_t          mq [2][$];
  logic          m_ovf [2];
  logic          m_rdv [2];
  ent_t          m_rd  [2];
  logic          m_halted, m_hprev;
  logic [AW-1:0] m_hpc;
  int            m_ic;
  logic [WC-1:0] m_hit;
  logic [DW-1:0] m_wd [WC];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: each trace is a bounded queue of entries.
  task automatic model_update();
    ent_t e;
    logic acc;
    if (rst || clr) begin
      for (int g = 0; g < 2; g++) begin
        mq[g].delete();
        m_ovf[g] = 1'b0;
        m_rdv[g] = 1'b0;
        m_rd[g]  = '0;
      end
      m_halted = 1'b0;
      m_hprev  = 1'b0;
      m_hpc    = '0;
      m_ic     = 0;
      m_hit    = '0;
      for (int i = 0; i < WC; i++) m_wd[i] = '0;
      return;
    end
    e   = {pc_addr, opcode, ir_addr, data};
    acc = fetch_valid && !m_halted;
    for (int g = 0; g < 2; g++) begin
      m_rdv[g] = 1'b0;
      if (rd_en && mq[g].size() != 0) begin
        m_rd[g]  = mq[g].pop_front();
        m_rdv[g] = 1'b1;
      end
      if (acc) begin
        if (mq[g].size() < D) mq[g].push_back(e);
        else begin
          m_ovf[g] = 1'b1;
          if (g == 1) begin
            void'(mq[g].pop_front());
            mq[g].push_back(e);
          end
        end
      end
    end
    if (acc && m_ic < 2**NW - 1) m_ic++;
    if (halt && !m_hprev) begin
      m_halted = 1'b1;
      m_hpc    = pc_addr;
    end
    m_hprev = halt;
    for (int i = 0; i < WC; i++) begin
      m_hit[i] = mem_wr && (wr_addr == watch_addr[i*AW +: AW]);
      if (m_hit[i]) m_wd[i] = wr_data;
    end
  endtask

  task automatic check_all();
    logic [WC*DW-1:0] wexp;
    for (int i = 0; i < WC; i++) wexp[i*DW +: DW] = m_wd[i];
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("w%0d count", g), 64'(count_o[g]), 64'(mq[g].size()));
      chk($sformatf("w%0d empty", g), 64'(empty_o[g]),
          64'(mq[g].size() == 0));
      chk($sformatf("w%0d full", g), 64'(full_o[g]),
          64'(mq[g].size() == D));
      chk($sformatf("w%0d overflow", g), 64'(ovf_o[g]), 64'(m_ovf[g]));
      chk($sformatf("w%0d rd_valid", g), 64'(rd_valid_o[g]), 64'(m_rdv[g]));
      chk($sformatf("w%0d rd_entry", g),
          64'({rd_pc_o[g], rd_op_o[g], rd_addr_o[g], rd_data_o[g]}),
          64'(m_rd[g]));
      chk($sformatf("w%0d halted", g), 64'(halted_o[g]), 64'(m_halted));
      chk($sformatf("w%0d halt_pc", g), 64'(hpc_o[g]), 64'(m_hpc));
      chk($sformatf("w%0d instr_count", g), 64'(ic_o[g]), 64'(m_ic));
      chk($sformatf("w%0d watch_hit", g), 64'(hit_o[g]), 64'(m_hit));
      chk($sformatf("w%0d watch_data", g), 64'(wd_o[g]), 64'(wexp));
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic fetch(input int pc);
    fetch_valid = 1'b1;
    pc_addr     = AW'(pc);
    opcode      = OW'($urandom);
    ir_addr     = AW'($urandom);
    data        = DW'($urandom);
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  wv_t wv [6];

  initial begin
    wv[0] = '{wa: {5'h1B, 5'h1A}, wr: 1'b1, a: 5'h1A, d: 8'h37,
              hit: 2'b01, d0: 8'h37, d1: 8'h00};
    wv[1] = '{wa: {5'h1B, 5'h1A}, wr: 1'b1, a: 5'h1C, d: 8'h55,
              hit: 2'b00, d0: 8'h37, d1: 8'h00};
    wv[2] = '{wa: {5'h1B, 5'h1A}, wr: 1'b1, a: 5'h1B, d: 8'hA5,
              hit: 2'b10, d0: 8'h37, d1: 8'hA5};
    wv[3] = '{wa: {5'h1B, 5'h1A}, wr: 1'b0, a: 5'h1A, d: 8'hFF,
              hit: 2'b00, d0: 8'h37, d1: 8'hA5};
    wv[4] = '{wa: {5'h1B, 5'h1A}, wr: 1'b1, a: 5'h1A, d: 8'h12,
              hit: 2'b01, d0: 8'h12, d1: 8'hA5};
    wv[5] = '{wa: {5'h1A, 5'h1A}, wr: 1'b1, a: 5'h1A, d: 8'h99,
              hit: 2'b11, d0: 8'h99, d1: 8'h99};

    rst = 1'b0; clr = 1'b0; fetch_valid = 1'b0; halt = 1'b0;
    mem_wr = 1'b0; rd_en = 1'b0; pc_addr = '0; ir_addr = '0;
    wr_addr = '0; opcode = '0; data = '0; wr_data = '0;
    watch_addr = {5'h1B, 5'h1A};

    do_reset();
    chk("reset empty", 64'(empty_o[1]), 64'd1);
    chk("reset count", 64'(count_o[1]), 64'd0);
    pop();
    chk("empty pop rd_valid", 64'(rd_valid_o[1]), 64'd0);

    for (int i = 0; i < 5; i++) fetch(i);
    chk("t1 count", 64'(count_o[1]), 64'd5);
    for (int i = 0; i < 5; i++) begin
      pop();
      chk("t1 rd_valid", 64'(rd_valid_o[1]), 64'd1);
      chk("t1 rd_pc", 64'(rd_pc_o[1]), 64'(i));
    end
    chk("t1 empty", 64'(empty_o[1]), 64'd1);
    chk("t1 count end", 64'(count_o[1]), 64'd0);

    do_reset();
    for (int i = 0; i < 20; i++) fetch(i);
    for (int g = 0; g < 2; g++) begin
      chk("t23 count", 64'(count_o[g]), 64'd16);
      chk("t23 overflow", 64'(ovf_o[g]), 64'd1);
      chk("t23 instr_count", 64'(ic_o[g]), 64'd20);
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("t2 wrap rd_pc", 64'(rd_pc_o[1]), 64'(i + 4));
      chk("t3 drop rd_pc", 64'(rd_pc_o[0]), 64'(i));
    end

    do_reset();
    for (int i = 0; i < 16; i++) fetch(i);
    fetch_valid = 1'b1; rd_en = 1'b1; pc_addr = 5'd16;
    step();
    fetch_valid = 1'b0; rd_en = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("t4 count", 64'(count_o[g]), 64'd16);
      chk("t4 overflow", 64'(ovf_o[g]), 64'd0);
      chk("t4 rd_pc", 64'(rd_pc_o[g]), 64'd0);
    end
    for (int i = 1; i <= 16; i++) begin
      pop();
      chk("t4 drain rd_pc", 64'(rd_pc_o[1]), 64'(i));
    end

    do_reset();
    for (int k = 0; k < 6; k++) begin
      watch_addr = wv[k].wa;
      mem_wr     = wv[k].wr;
      wr_addr    = wv[k].a;
      wr_data    = wv[k].d;
      step();
      chk($sformatf("t5[%0d] hit", k), 64'(hit_o[1]), 64'(wv[k].hit));
      chk($sformatf("t5[%0d] data0", k), 64'(wd_o[1][DW-1:0]), 64'(wv[k].d0));
      chk($sformatf("t5[%0d] data1", k), 64'(wd_o[1][2*DW-1:DW]),
          64'(wv[k].d1));
    end
    mem_wr = 1'b0;
    watch_addr = {5'h1B, 5'h1A};

    do_reset();
    fetch(1);
    fetch(2);
    halt = 1'b1; fetch_valid = 1'b1; pc_addr = 5'h17;
    step();
    fetch_valid = 1'b0;
    chk("t6 halted", 64'(halted_o[1]), 64'd1);
    chk("t6 halt_pc", 64'(hpc_o[1]), 64'h17);
    chk("t6 edge capture", 64'(count_o[1]), 64'd3);
    fetch(3);
    halt = 1'b0;
    fetch(4);
    chk("t6 no capture", 64'(count_o[1]), 64'd3);
    chk("t6 instr_count", 64'(ic_o[1]), 64'd3);
    mem_wr = 1'b1; wr_addr = 5'h1B; wr_data = 8'h6C;
    step();
    mem_wr = 1'b0;
    chk("t6 watch after halt", 64'(hit_o[1]), 64'b10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t6 clr halted", 64'(halted_o[1]), 64'd0);
    chk("t6 clr count", 64'(count_o[1]), 64'd0);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      fetch_valid = ($urandom_range(0, 1) == 1);
      rd_en       = ($urandom_range(0, 9) < 4);
      pc_addr     = AW'($urandom);
      opcode      = OW'($urandom);
      ir_addr     = AW'($urandom);
      data        = DW'($urandom);
      mem_wr      = ($urandom_range(0, 9) < 3);
      wr_addr     = AW'($urandom_range(0, 3));
      wr_data     = DW'($urandom);
      if ($urandom_range(0, 31) == 0)
        watch_addr = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 255) == 0);
      step();
    end
    rst = 1'b0; clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
